// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - runtime-programmable serial pattern scan controller
// Idle-input timeout is compiled in only when PATTERN_SCAN_TIMEOUT_EN is defined.
module pattern_scan_ctrl #(
  parameter int PAT_W       = 4,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int LEN_W       = $clog2(PAT_W) + 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_max_hits,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              detected,
  output logic [CNT_W-1:0]  hit_count,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              timeout,
  output logic [1:0]        prs_st
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [PAT_W-1:0]  pat_r;
  logic [LEN_W-1:0]  len_r;
  logic              ovl_r;
  logic [CNT_W-1:0]  max_r;
  logic [DATA_W-1:0] word_r;
  logic [IDX_W-1:0]  bit_idx;
  logic [PAT_W-1:0]  hist, hist_next, len_mask;
  logic [LEN_W-1:0]  fill, fill_next;
  logic [CNT_W-1:0]  hit_inc;
  logic              len_ok, handshake, match, budget_hit, tmo_hit;

  // Only the low len bits of history take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
  end

  assign len_ok     = (len_r != '0) && (len_r <= LEN_MAX);
  assign hist_next  = {hist[PAT_W-2:0], word_r[bit_idx]};
  assign fill_next  = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
  assign hit_inc    = (hit_count == CNT_SAT) ? hit_count : hit_count + CNT_W'(1);
  assign handshake  = in_valid && in_ready;
  assign match      = (state == S_SHIFT) && (fill_next >= len_r) &&
                      (((hist_next ^ pat_r) & len_mask) == '0);
  assign budget_hit = match && (max_r != '0) && (hit_inc == max_r);

`ifdef PATTERN_SCAN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_r;

  assign tmo_hit = (state == S_ARMED) && !in_valid && (tmo_cnt == TMO_LAST);
  assign timeout = timeout_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= tmo_hit && !abort;
      if ((state == S_ARMED) && (state_next == S_ARMED) && !in_valid)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      else
        tmo_cnt <= '0;
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYC != 0);
  assign tmo_hit    = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    prs_st     = state;
    case (state)
      S_IDLE: begin
        if (start && len_ok) state_next = S_ARMED;
      end
      S_ARMED: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake)    state_next = S_SHIFT;
        else if (tmo_hit) state_next = S_DONE;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (budget_hit)          state_next = S_DONE;
        else if (bit_idx == '0)  state_next = S_ARMED;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= PAT_W'(4'b1011);
      len_r     <= LEN_W'(4);
      ovl_r     <= 1'b0;
      max_r     <= '0;
      word_r    <= '0;
      bit_idx   <= '0;
      hist      <= '0;
      fill      <= '0;
      hit_count <= '0;
      detected  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      detected <= 1'b0;
      cfg_err  <= 1'b0;
      if (!abort) begin
        case (state)
          S_IDLE: begin
            // start evaluates len_r, so a same-cycle cfg_we lands after it.
            if (cfg_we) begin
              pat_r <= cfg_pattern;
              len_r <= cfg_len;
              ovl_r <= cfg_overlap;
              max_r <= cfg_max_hits;
            end
            if (start) begin
              if (len_ok) begin
                hit_count <= '0;
                hist      <= '0;
                fill      <= '0;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_ARMED: begin
            if (handshake) begin
              word_r  <= in_data;
              bit_idx <= IDX_MSB;
            end
          end
          S_SHIFT: begin
            hist    <= hist_next;
            bit_idx <= bit_idx - IDX_W'(1);
            if (match) begin
              detected  <= 1'b1;
              hit_count <= hit_inc;
              fill      <= ovl_r ? fill_next : '0;
            end else begin
              fill <= fill_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
